// File: rtl/dma_ctrl_pkg.sv
// Shared register map, bit positions and FSM state types for the DMA control block.
package dma_ctrl_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_SRC    = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_LEN    = 3'd4;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        RD_RESP  = 1'b1
    } acc_state_t;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_START = 2'd1,
        CH_BUSY  = 2'd2
    } ch_state_t;

    // Transfer configuration registers that are locked while a transfer runs.
    function automatic logic is_cfg_reg(input logic [2:0] sel);
        return (sel == REG_SRC) || (sel == REG_DST) || (sel == REG_LEN);
    endfunction

endpackage

// File: rtl/dma_ch_seq.sv
// Channel sequencer: start handshake toward the DMA engine plus BUSY/DONE/ERR flags.
module dma_ch_seq
    import dma_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic start_wr_i,
    input  logic len_zero_i,
    input  logic cfg_wr_i,
    input  logic done_clr_i,
    input  logic err_clr_i,
    input  logic start_ready_i,
    input  logic done_i,
    input  logic err_i,
    output logic start_valid_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);

    ch_state_t state_q, state_d;
    logic      done_q, done_d;
    logic      err_q, err_d;
    logic      done_set, err_set;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= CH_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (start_wr_i) begin
                    if (len_zero_i) err_set = 1'b1;
                    else            state_d = CH_START;
                end
            end
            CH_START: begin
                if (start_wr_i || cfg_wr_i) err_set = 1'b1;
                if (start_ready_i) state_d = CH_BUSY;
            end
            CH_BUSY: begin
                if (start_wr_i || cfg_wr_i) err_set = 1'b1;
                if (done_i) done_set = 1'b1;
                if (err_i)  err_set  = 1'b1;
                if (done_i || err_i) state_d = CH_IDLE;
            end
            default: state_d = CH_IDLE;
        endcase
        // A hardware set in the same cycle as a software clear must survive.
        done_d = done_set | (done_q & ~done_clr_i);
        err_d  = err_set  | (err_q  & ~err_clr_i);
    end

    assign start_valid_o = (state_q == CH_START);
    assign busy_o        = (state_q != CH_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: rtl/dma_ctrl_regs.sv
// DMA configuration register file and bus access FSM behind the APB slave request bus.
module dma_ctrl_regs
    import dma_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk_apb,
    input  logic                  i_rstn_apb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [DATA_WIDTH-1:0] o_src_addr,
    output logic [DATA_WIDTH-1:0] o_dst_addr,
    output logic [LEN_WIDTH-1:0]  o_len,
    output logic                  o_start_valid,
    input  logic                  i_start_ready,
    input  logic                  i_done,
    input  logic                  i_err,
    output logic                  o_irq
);

    acc_state_t            acc_q, acc_d;
    logic [DATA_WIDTH-1:0] src_q, src_d;
    logic [DATA_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic [2:0] sel;
    logic       wr_acc, rd_acc;
    logic       start_wr, cfg_wr, done_clr, err_clr;
    logic       busy, done_flag, err_flag;
    logic       unused_addr;

    assign sel         = i_addr[4:2];
    assign unused_addr = ^{i_addr[ADDR_WIDTH-1:5], i_addr[1:0]};

    assign wr_acc   = i_valid & o_ready & i_rd0_wr1;
    assign rd_acc   = i_valid & o_ready & ~i_rd0_wr1;
    assign start_wr = wr_acc & (sel == REG_CTRL) & i_wr_data[CTRL_START_BIT];
    assign cfg_wr   = wr_acc & is_cfg_reg(sel);
    assign done_clr = wr_acc & (sel == REG_STATUS) & i_wr_data[STAT_DONE_BIT];
    assign err_clr  = wr_acc & (sel == REG_STATUS) & i_wr_data[STAT_ERR_BIT];

    dma_ch_seq u_ch_seq (
        .clk_i         (i_clk_apb),
        .rstn_i        (i_rstn_apb),
        .start_wr_i    (start_wr),
        .len_zero_i    (len_q == '0),
        .cfg_wr_i      (cfg_wr),
        .done_clr_i    (done_clr),
        .err_clr_i     (err_clr),
        .start_ready_i (i_start_ready),
        .done_i        (i_done),
        .err_i         (i_err),
        .start_valid_o (o_start_valid),
        .busy_o        (busy),
        .done_o        (done_flag),
        .err_o         (err_flag)
    );

    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            acc_q     <= ACC_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            acc_q     <= acc_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        o_ready    = 1'b0;
        o_rd_valid = 1'b0;
        case (acc_q)
            ACC_IDLE: begin
                o_ready = 1'b1;
                if (i_valid && !i_rd0_wr1) acc_d = RD_RESP;
            end
            RD_RESP: begin
                o_rd_valid = 1'b1;
                acc_d      = ACC_IDLE;
            end
            default: acc_d = ACC_IDLE;
        endcase
    end

    // Transfer parameters are frozen while the channel is busy.
    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        if (wr_acc) begin
            case (sel)
                REG_CTRL: irq_en_d = i_wr_data[CTRL_IRQ_EN_BIT];
                REG_SRC:  if (!busy) src_d = i_wr_data;
                REG_DST:  if (!busy) dst_d = i_wr_data;
                REG_LEN:  if (!busy) len_d = i_wr_data[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_CTRL: rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
            REG_STATUS: begin
                rd_mux[STAT_BUSY_BIT] = busy;
                rd_mux[STAT_DONE_BIT] = done_flag;
                rd_mux[STAT_ERR_BIT]  = err_flag;
            end
            REG_SRC: rd_mux = src_q;
            REG_DST: rd_mux = dst_q;
            REG_LEN: rd_mux[LEN_WIDTH-1:0] = len_q;
            default: ;
        endcase
    end

    assign rd_data_d = rd_acc ? rd_mux : rd_data_q;
    assign irq_d     = irq_en_q & (done_flag | err_flag);

    assign o_rd_data  = o_rd_valid ? rd_data_q : '0;
    assign o_src_addr = src_q;
    assign o_dst_addr = dst_q;
    assign o_len      = len_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// Randomized and directed bench for dma_ctrl_regs against a register-level reference model.
module tb_dma_ctrl_regs;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_SRC    = 32'h08;
    localparam logic [31:0] A_DST    = 32'h0C;
    localparam logic [31:0] A_LEN    = 32'h10;

    logic        i_clk_apb, i_rstn_apb, i_valid, i_rd0_wr1;
    logic [31:0] i_addr, i_wr_data;
    logic        o_ready, o_rd_valid;
    logic [31:0] o_rd_data, o_src_addr, o_dst_addr;
    logic [15:0] o_len;
    logic        o_start_valid, i_start_ready, i_done, i_err, o_irq;

    int tests_run, tests_failed;

    // Reference model state: register contents, flags and channel phase (0 idle, 1 start, 2 busy).
    logic [31:0] m_src, m_dst, m_rd_data;
    logic [15:0] m_len;
    bit          m_irq_en, m_done, m_err, m_irq, m_rdv;
    int          m_phase;
    bit          start_rdy;

    dma_ctrl_regs dut (
        .i_clk_apb     (i_clk_apb),
        .i_rstn_apb    (i_rstn_apb),
        .i_valid       (i_valid),
        .i_rd0_wr1     (i_rd0_wr1),
        .i_addr        (i_addr),
        .i_wr_data     (i_wr_data),
        .o_ready       (o_ready),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .o_src_addr    (o_src_addr),
        .o_dst_addr    (o_dst_addr),
        .o_len         (o_len),
        .o_start_valid (o_start_valid),
        .i_start_ready (i_start_ready),
        .i_done        (i_done),
        .i_err         (i_err),
        .o_irq         (o_irq)
    );

    initial begin
        i_clk_apb = 1'b0;
        forever #5 i_clk_apb = ~i_clk_apb;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic model_reset();
        m_src = '0; m_dst = '0; m_len = '0; m_rd_data = '0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_irq = 0; m_rdv = 0; m_phase = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [2:0] s;
        s = a[4:2];
        case (s)
            3'd0:    return {30'd0, m_irq_en, 1'b0};
            3'd1:    return {29'd0, m_err, m_done, (m_phase != 0)};
            3'd2:    return m_src;
            3'd3:    return m_dst;
            3'd4:    return {16'd0, m_len};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit acc, input bit w, input logic [31:0] a, input logic [31:0] d,
                              input bit rdy, input bit dn, input bit er);
        logic [2:0] s;
        bit busy, sd, se;
        int nph;
        s = a[4:2]; busy = (m_phase != 0); sd = 0; se = 0; nph = m_phase;
        m_irq = m_irq_en & (m_done | m_err);
        if (acc && !w) m_rd_data = model_read(a);
        m_rdv = acc && !w;
        if (m_phase == 1 && rdy) nph = 2;
        if (m_phase == 2 && (dn || er)) begin sd = dn; se = er; nph = 0; end
        if (acc && w) begin
            case (s)
                3'd0: begin
                    m_irq_en = d[1];
                    if (d[0]) begin
                        if (busy || m_len == 0) se = 1;
                        else nph = 1;
                    end
                end
                3'd1: begin
                    if (d[1]) m_done = 0;
                    if (d[2]) m_err = 0;
                end
                3'd2: if (busy) se = 1; else m_src = d;
                3'd3: if (busy) se = 1; else m_dst = d;
                3'd4: if (busy) se = 1; else m_len = d[15:0];
                default: ;
            endcase
        end
        if (sd) m_done = 1;
        if (se) m_err = 1;
        m_phase = nph;
    endtask

    task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit dn, input bit er);
        bit acc;
        @(negedge i_clk_apb);
        i_valid = v; i_rd0_wr1 = w; i_addr = a; i_wr_data = d;
        i_start_ready = start_rdy; i_done = dn; i_err = er;
        acc = v && !m_rdv;
        @(posedge i_clk_apb);
        model_edge(acc, w, a, d, start_rdy, dn, er);
        #1;
        i_valid = 0; i_rd0_wr1 = 0; i_done = 0; i_err = 0; i_start_ready = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1, 1, a, d, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 32'd0, 32'd0, 0, 0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] data, output bit pulse_ok);
        bit v1, v2;
        step(1, 0, a, 32'd0, 0, 0);
        data = o_rd_data; v1 = o_rd_valid;
        idle();
        v2 = o_rd_valid;
        pulse_ok = v1 && !v2 && (o_rd_data == 32'd0);
    endtask

    task automatic start_xfer();
        start_rdy = 1;
        wr(A_CTRL, 32'h3);
        idle();
        start_rdy = 0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        logic [31:0] got;
        bit ok;
        addrs = '{A_STATUS, A_SRC, A_LEN};
        i_rstn_apb = 1; i_valid = 0; i_rd0_wr1 = 0; i_addr = 0; i_wr_data = 0;
        i_start_ready = 0; i_done = 0; i_err = 0; start_rdy = 0;
        #2 i_rstn_apb = 0;
        #10;
        tests_run++;
        if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        tests_run++;
        if ({o_rd_valid, o_start_valid, o_irq} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctl: got %b want 000", {o_rd_valid, o_start_valid, o_irq});
        end
        tests_run++;
        if ({o_src_addr, o_dst_addr, o_len, o_rd_data} !== '0) begin
            tests_failed++; $display("FAIL reset_data: src %h dst %h len %h rd %h want 0", o_src_addr, o_dst_addr, o_len, o_rd_data);
        end
        @(negedge i_clk_apb);
        i_rstn_apb = 1;
        model_reset();
        foreach (addrs[i]) begin
            rd(addrs[i], got, ok);
            tests_run++;
            if (got !== 32'd0 || !ok) begin
                tests_failed++; $display("FAIL reset_read_%0d: got %h pulse %b want 0 pulse 1", i, got, ok);
            end
        end
    endtask

    task automatic test_config();
        logic [31:0] a, d, got, exp;
        logic [2:0] s;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            s = 3'($urandom_range(0, 7));
            a = ($urandom() & 32'hFFFF_FFE3) | (32'(s) << 2);
            d = $urandom();
            if (s == 3'd0) d[0] = 1'b0;
            wr(a, d);
            exp = model_read(a);
            rd(a, got, ok);
            tests_run++;
            if (got !== exp || !ok) begin
                tests_failed++; $display("FAIL cfg_rand_%0d: addr %h got %h want %h pulse %b", i, a, got, exp, ok);
            end
        end
        wr(A_SRC, 32'h1000);
        wr(A_DST, 32'h2000);
        wr(A_LEN, 32'h40);
        rd(A_SRC, got, ok);
        tests_run++;
        if (got !== 32'h1000) begin tests_failed++; $display("FAIL cfg_src: got %h want 1000", got); end
        rd(A_DST, got, ok);
        tests_run++;
        if (got !== 32'h2000) begin tests_failed++; $display("FAIL cfg_dst: got %h want 2000", got); end
        rd(A_LEN, got, ok);
        tests_run++;
        if (got !== 32'h40) begin tests_failed++; $display("FAIL cfg_len: got %h want 40", got); end
        tests_run++;
        if ({o_src_addr, o_dst_addr, o_len} !== {32'h1000, 32'h2000, 16'h40}) begin
            tests_failed++; $display("FAIL cfg_outs: src %h dst %h len %h want 1000 2000 40", o_src_addr, o_dst_addr, o_len);
        end
    endtask

    task automatic test_start_irq();
        logic [31:0] got;
        bit ok;
        int cnt;
        wr(A_STATUS, 32'h6);
        wr(A_CTRL, 32'h3);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_start_valid) cnt++;
            start_rdy = (i == 3);
            idle();
        end
        start_rdy = 0;
        tests_run++;
        if (cnt != 4) begin tests_failed++; $display("FAIL start_valid_len: got %0d cycles want 4", cnt); end
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h1) begin tests_failed++; $display("FAIL start_busy: got %h want 1", got); end
        step(0, 0, 32'd0, 32'd0, 1, 0);
        tests_run++;
        if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_early: got %b want 0", o_irq); end
        idle();
        tests_run++;
        if (o_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set: got %b want 1", o_irq); end
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h2) begin tests_failed++; $display("FAIL done_status: got %h want 2", got); end
        wr(A_STATUS, 32'h2);
        idle();
        tests_run++;
        if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_clr: got %b want 0", o_irq); end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        bit ok, seen;
        wr(A_LEN, 32'h0);
        wr(A_CTRL, 32'h3);
        seen = o_start_valid;
        idle(); seen |= o_start_valid;
        idle(); seen |= o_start_valid;
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL len0_start: got start_valid 1 want 0"); end
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h4) begin tests_failed++; $display("FAIL len0_err: got %h want 4", got); end
        wr(A_STATUS, 32'h4);
        wr(A_LEN, 32'h40);
        start_xfer();
        wr(A_LEN, 32'h80);
        wr(A_SRC, 32'hDEAD_BEEF);
        rd(A_LEN, got, ok);
        tests_run++;
        if (got !== 32'h40 || o_len !== 16'h40) begin
            tests_failed++; $display("FAIL busy_len: got %h o_len %h want 40", got, o_len);
        end
        tests_run++;
        if (o_src_addr !== 32'h1000) begin tests_failed++; $display("FAIL busy_src: got %h want 1000", o_src_addr); end
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h5) begin tests_failed++; $display("FAIL busy_err: got %h want 5", got); end
        wr(A_CTRL, 32'h3);
        tests_run++;
        if (o_start_valid !== 1'b0) begin tests_failed++; $display("FAIL busy_restart: got %b want 0", o_start_valid); end
        step(0, 0, 32'd0, 32'd0, 1, 0);
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h6) begin tests_failed++; $display("FAIL err_then_done: got %h want 6", got); end
        wr(A_STATUS, 32'h6);
    endtask

    task automatic test_simultaneous();
        logic [31:0] got;
        bit ok;
        start_xfer();
        step(0, 0, 32'd0, 32'd0, 1, 0);
        start_xfer();
        step(1, 1, A_STATUS, 32'h2, 1, 0);
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h2) begin tests_failed++; $display("FAIL w1c_vs_done: got %h want 2", got); end
        wr(A_STATUS, 32'h6);
        start_xfer();
        step(0, 0, 32'd0, 32'd0, 1, 1);
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h6) begin tests_failed++; $display("FAIL done_and_err: got %h want 6", got); end
        wr(A_STATUS, 32'h6);
        step(0, 0, 32'd0, 32'd0, 1, 0);
        step(0, 0, 32'd0, 32'd0, 0, 1);
        rd(A_STATUS, got, ok);
        tests_run++;
        if (got !== 32'h0) begin tests_failed++; $display("FAIL idle_events: got %h want 0", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bit rdy_ok;
        rdy_ok = 1;
        for (int i = 0; i < 6; i++) begin
            d = $urandom();
            rdy_ok &= o_ready;
            wr((i % 2) ? A_DST : A_SRC, d);
        end
        tests_run++;
        if (!rdy_ok || o_src_addr !== m_src || o_dst_addr !== m_dst) begin
            tests_failed++; $display("FAIL b2b_wr: ready %b src %h dst %h want 1 %h %h", rdy_ok, o_src_addr, o_dst_addr, m_src, m_dst);
        end
        step(1, 0, A_SRC, 32'd0, 0, 0);
        tests_run++;
        if (o_rd_valid !== 1'b1 || o_ready !== 1'b0 || o_rd_data !== m_src) begin
            tests_failed++; $display("FAIL b2b_rd1: valid %b ready %b data %h want 1 0 %h", o_rd_valid, o_ready, o_rd_data, m_src);
        end
        step(1, 0, A_DST, 32'd0, 0, 0);
        tests_run++;
        if (o_rd_valid !== 1'b0 || o_ready !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_rd_blocked: valid %b ready %b want 0 1", o_rd_valid, o_ready);
        end
        step(1, 0, A_DST, 32'd0, 0, 0);
        tests_run++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== m_dst) begin
            tests_failed++; $display("FAIL b2b_rd2: valid %b data %h want 1 %h", o_rd_valid, o_rd_data, m_dst);
        end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [2:0] s;
        bit v, w, dn, er;
        logic [115:0] got, exp;
        wr(A_LEN, 32'h10);
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) < 6);
            w = 1'($urandom_range(0, 1));
            s = 3'($urandom_range(0, 7));
            a = ($urandom() & 32'hFFFF_FFE3) | (32'(s) << 2);
            d = $urandom();
            if (s == 3'd4 && $urandom_range(0, 3) == 0) d = 32'd0;
            dn = ($urandom_range(0, 9) == 0);
            er = ($urandom_range(0, 14) == 0);
            start_rdy = 1'($urandom_range(0, 1));
            step(v, w, a, d, dn, er);
            exp = {!m_rdv, m_rdv, (m_rdv ? m_rd_data : 32'd0), (m_phase == 1), m_irq, m_src, m_dst, m_len};
            got = {o_ready, o_rd_valid, o_rd_data, o_start_valid, o_irq, o_src_addr, o_dst_addr, o_len};
            tests_run++;
            if (got !== exp) begin
                tests_failed++; $display("FAIL rand_cycle_%0d: got %h want %h", i, got, exp);
            end
        end
        start_rdy = 1;
        repeat (3) step(0, 0, 32'd0, 32'd0, 1, 0);
        start_rdy = 0;
        wr(A_STATUS, 32'h6);
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        bit ok;
        for (int ph = 0; ph < 2; ph++) begin
            wr(A_STATUS, 32'h6);
            wr(A_SRC, 32'hA5A5_0000 | 32'(ph));
            wr(A_DST, 32'h5A5A_0000 | 32'(ph));
            wr(A_LEN, 32'h40);
            wr(A_CTRL, 32'h3);
            if (ph == 1) begin start_rdy = 1; idle(); start_rdy = 0; end
            wr(A_LEN, 32'h80);
            idle();
            tests_run++;
            if (o_irq !== 1'b1 || o_start_valid !== (ph == 0)) begin
                tests_failed++; $display("FAIL rstmid_pre_%0d: irq %b start %b want 1 %b", ph, o_irq, o_start_valid, (ph == 0));
            end
            @(negedge i_clk_apb);
            #2 i_rstn_apb = 0;
            #1;
            tests_run++;
            if ({o_start_valid, o_irq, o_rd_valid, o_ready} !== 4'b0001 ||
                {o_src_addr, o_dst_addr, o_len} !== '0) begin
                tests_failed++;
                $display("FAIL rstmid_%0d: start %b irq %b rdv %b ready %b src %h dst %h len %h want 0 0 0 1 0 0 0",
                         ph, o_start_valid, o_irq, o_rd_valid, o_ready, o_src_addr, o_dst_addr, o_len);
            end
            @(negedge i_clk_apb);
            i_rstn_apb = 1;
            model_reset();
            step(0, 0, 32'd0, 32'd0, 1, 0);
            rd(A_STATUS, got, ok);
            tests_run++;
            if (got !== 32'h0 || o_start_valid !== 1'b0 || o_irq !== 1'b0) begin
                tests_failed++; $display("FAIL rstmid_after_%0d: status %h start %b irq %b want 0 0 0", ph, got, o_start_valid, o_irq);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_reset();
        test_reset();
        test_config();
        test_start_irq();
        test_errors();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_ctrl_regs.md
Name: dma_ctrl_regs

Overview:
Configuration and sequencing block for the DMA engine. It sits behind the APB slave on that slave's internal request bus (valid / rd0_wr1 / addr / wr_data, ready / rd_valid / rd_data). It holds the DMA transfer registers (source, destination, length, control, status) and drives a start handshake into the DMA datapath. It tracks busy/done/error and raises an interrupt on completion.

Parameters:
DATA_WIDTH, 32, width of internal bus data and of address registers
ADDR_WIDTH, 32, width of internal bus address
LEN_WIDTH, 16, width of transfer length register (bytes); must be <= DATA_WIDTH

Ports:
i_clk_apb  in  1  APB-domain clock
i_rstn_apb  in  1  asynchronous active-low reset
i_valid  in  1  internal bus request valid (from APB slave)
i_rd0_wr1  in  1  0 = read, 1 = write
i_addr  in  ADDR_WIDTH  byte address; only i_addr[4:2] decoded
i_wr_data  in  DATA_WIDTH  write data
o_ready  out  1  request accepted this cycle when high with i_valid
o_rd_valid  out  1  read data valid, single-cycle pulse
o_rd_data  out  DATA_WIDTH  read data, valid only with o_rd_valid, else 0
o_src_addr  out  DATA_WIDTH  DMA source address
o_dst_addr  out  DATA_WIDTH  DMA destination address
o_len  out  LEN_WIDTH  DMA transfer length
o_start_valid  out  1  start request to DMA engine
i_start_ready  in  1  DMA engine accepts start
i_done  in  1  transfer complete pulse from DMA engine
i_err  in  1  transfer error pulse from DMA engine
o_irq  out  1  level interrupt

Behaviour:
Clock and reset: one clock, i_clk_apb. Reset i_rstn_apb is asynchronous, active-low. All registers, FSMs and outputs reset to 0, except o_ready, which reads 1 once the bus FSM is in ACC_IDLE (it is 1 during reset).

Register map (i_addr[4:2]):
- 0x00 CTRL: bit0 START (write-1 action, reads 0); bit1 IRQ_EN (RW).
- 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C).
- 0x08 SRC (RW).
- 0x0C DST (RW).
- 0x10 LEN (RW, LEN_WIDTH LSBs, upper bits read 0).
- 0x14-0x1C: unmapped. Reads return 0; writes are ignored and set no flags.

Bus FSM (ACC_IDLE, RD_RESP):
- ACC_IDLE: o_ready = 1. When i_valid is high:
  - Write: takes effect at this clock edge; stay in ACC_IDLE.
  - Read: capture register value at this edge; go to RD_RESP.
- RD_RESP: o_ready = 0; o_rd_valid = 1 with captured data; return to ACC_IDLE next cycle.
- Read latency is exactly 1 cycle after acceptance. Back-to-back writes are accepted every cycle. A read may be accepted at most every 2 cycles.

Channel FSM (CH_IDLE, CH_START, CH_BUSY):
- CH_IDLE, write of CTRL.START = 1:
  - LEN != 0: go to CH_START, BUSY = 1.
  - LEN == 0: ERR = 1, stay in CH_IDLE.
- CH_START: o_start_valid = 1, held until i_start_ready. On the handshake cycle go to CH_BUSY.
- CH_BUSY:
  - i_done: DONE = 1, BUSY = 0, go to CH_IDLE.
  - i_err: ERR = 1, BUSY = 0, go to CH_IDLE.
  - Both in the same cycle: set both flags.
- BUSY = 1 in CH_START and CH_BUSY.
- START while BUSY: ignored, ERR = 1.
- Writes to SRC/DST/LEN while BUSY: ignored, ERR = 1. o_src_addr, o_dst_addr and o_len stay stable for the whole transfer.
- i_done/i_err outside CH_BUSY: ignored.
- W1C on the same cycle as a hardware set of the same bit: the set wins.
- o_irq = IRQ_EN & (DONE | ERR), registered (1-cycle delay after flag update).
- Reset asserted mid-transfer: everything returns to 0 asynchronously. o_start_valid drops immediately; a pending engine completion is then ignored.

Decomposition:
- Package dma_ctrl_pkg:
  - register offset localparams (CTRL/STATUS/SRC/DST/LEN);
  - CTRL/STATUS bit-position constants;
  - typedef enum acc_state_t {ACC_IDLE, RD_RESP};
  - typedef enum ch_state_t {CH_IDLE, CH_START, CH_BUSY}.
- One sub-module, dma_ch_seq: the channel FSM plus BUSY/DONE/ERR flag logic and o_start_valid. The top keeps the register file, bus FSM and read mux.

Test Plan:
- Reset, then read STATUS/SRC/LEN -> o_ready = 1, o_rd_valid pulses exactly 1 cycle after accept, data 0x0.
- Write SRC = 0x1000, DST = 0x2000, LEN = 0x40, then read back -> 0x1000, 0x2000, 0x40; o_src_addr/o_dst_addr/o_len match.
- With IRQ_EN = 1, START; hold i_start_ready = 0 for 3 cycles, then 1 -> o_start_valid high for 4 cycles, STATUS = 0x1. After an i_done pulse: STATUS = 0x2, o_irq = 1 one cycle later. W1C 0x2 -> o_irq = 0.
- Error cases:
  - START with LEN = 0 -> no o_start_valid, STATUS.ERR = 1.
  - During BUSY, write LEN = 0x80 -> LEN still reads 0x40, ERR = 1.
- Simultaneous events:
  - i_done in the same cycle as a W1C of DONE -> DONE reads 1.
  - i_done and i_err together -> STATUS = 0x6.
  - i_done while idle -> STATUS unchanged.
- Assert i_rstn_apb low while in CH_BUSY -> o_start_valid, o_irq and all registers 0 immediately. A later i_done is ignored.
